au_param: RTL and testbench
===========================

# au_param

Parametrised sign-magnitude fixed-point arithmetic unit, successor to the fixed-width `au`. It executes ADD, SUB, MULT and an optional iterative DIV on W-bit operands with FRAC fraction bits. Every op is a two-stage compute/finalise sequence with saturation, an overflow flag and round-half-away-from-zero multiplication. It sits under the Kalman-filter datapath sequencer and uses the same start/busy/done handshake as `au`.

## Interface
- `W`, 24, total word width: 1 sign bit plus W-1 magnitude bits (S(W-1-FRAC).FRAC).
- `FRAC`, 14, fraction bits; legal range is 1 ≤ FRAC ≤ W-2.
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `R_in` input W: operand X, sign-magnitude.
- `S_in` input W: operand Y source 0.
- `Iimm_in` input W: operand Y source 1 (immediate).
- `op_sel` input 2: 00 ADD, 01 SUB, 10 MULT, 11 DIV.
- `mul_y_sel` input 2: Y for MULT/DIV. 00 S_in; 01 Iimm_in; 10 constant +1.0 (1<<FRAC); 11 S_in. ADD/SUB always use S_in.
- `result` output W: registered result, held until the next done.
- `done` output 1: one-cycle pulse when `result` updates.
- `busy` output 1: high while an op is in flight.
- `ovf` output 1: saturation or divide-by-zero on the last op; updated with `done`.
- `err` output 1: illegal op on the last op; updated with `done`.

## Operation
- States: IDLE, EXEC, DIV, FIN.
- IDLE: on start=1, latch R_in, the selected Y and op_sel. Next state is EXEC for ADD/SUB/MULT and DIV for DIV. Inputs may change after the accept edge.
- EXEC: compute the raw wide result into the stage register, then go to FIN.
  - ADD/SUB: SUB flips Y's sign. Equal signs add magnitudes. Differing signs subtract the smaller magnitude from the larger, and the result takes the larger operand's sign.
  - MULT: 2(W-1)-bit magnitude product, plus 1<<(FRAC-1), shifted right by FRAC. Result sign is sign(X) XOR sign(Y).
- DIV: restoring divide of |X|<<FRAC by |Y|, producing N = W-1+FRAC quotient bits, one per cycle, MSB first, truncated.
  - An iteration counter runs 0..N-1, then the state goes to FIN.
  - If |Y|=0, skip the iterations and go to FIN with a forced divide-by-zero condition.
- FIN:
  - Any magnitude > 2^(W-1)-1 clamps to 2^(W-1)-1 and sets ovf=1.
  - Divide-by-zero gives magnitude 2^(W-1)-1 with sign(X) and ovf=1.
  - Zero magnitude always forces sign 0, so -0 is never emitted.
  - Register `result`, `ovf` and `err`; pulse `done`; return to IDLE.
- `busy` is high in EXEC, DIV and FIN, and low in IDLE.
- `start` while busy is ignored; there is no queueing.
- `rst` at any point aborts the op: state goes to IDLE with no done pulse, and every output takes its reset value.

## Timing
- Reset values: result=0, done=0, busy=0, ovf=0, err=0, state IDLE.
- Edge E0 accepts start.
- ADD/SUB/MULT: EXEC at E1, FIN at E2, so done and result are valid after E2 (latency 2).
- DIV: N iterations at E1..EN, FIN at E(N+1) (latency N+1; 38 for the defaults).
- DIV by zero: latency 2.
- `done` is high exactly one cycle.
- Earliest re-accept: start is sampled in the cycle after `done` (back-to-back throughput of 3 cycles for simple ops).
- `result` is stable between done pulses.

## Configuration
- `AU_DIV_EN` defined: DIV state and divider are compiled in; op 11 behaves as specified.
- `AU_DIV_EN` undefined: the divider is removed. Op 11 goes through EXEC and FIN with result=0, err=1, ovf=0 and latency 2. `err` is 0 for all other ops in both builds.

## Test plan
- ADD/SUB sweep over integers -4..4 for both (defaults): result equals the exact sign-magnitude value. 3-3 → 0x000000, never 0x800000. done arrives two edges after accept.
- MULT 3 × -2 → 0x818000. MULT with mul_y_sel=01 and Iimm=0x002000 (0.5) on R=0x006000 (1.5) → 0x003000 (0.75). mul_y_sel=10 returns R unchanged.
- Saturation: 300.0 + 300.0 (0x4B0000 + 0x4B0000) → 0x7FFFFF, ovf=1. The next op 1+1 → 0x008000 with ovf=0.
- DIV (AU_DIV_EN): 7.0 / 2.0 → 0x00E000 with done exactly 38 edges after accept. -5.0 / 0 → 0xFFFFFF, ovf=1, latency 2. Without AU_DIV_EN, op 11 → result 0x000000, err=1.
- Handshake: start held high through a DIV starts exactly one op. rst pulsed mid-DIV gives no done, all outputs 0 next cycle, and a new op is accepted immediately after.

Source files
------------

// File: rtl/au_param_if.sv
// Start/busy/done handshake and operand/result bus of the au_param arithmetic unit.
interface au_param_if #(parameter int unsigned W = 24);
    logic         start;
    logic [W-1:0] R_in;
    logic [W-1:0] S_in;
    logic [W-1:0] Iimm_in;
    logic [1:0]   op_sel;
    logic [1:0]   mul_y_sel;
    logic [W-1:0] result;
    logic         done;
    logic         busy;
    logic         ovf;
    logic         err;

    modport master (
        output start, R_in, S_in, Iimm_in, op_sel, mul_y_sel,
        input  result, done, busy, ovf, err
    );

    modport slave (
        input  start, R_in, S_in, Iimm_in, op_sel, mul_y_sel,
        output result, done, busy, ovf, err
    );
endinterface

// File: rtl/au_param.sv
// Sign-magnitude fixed-point ADD/SUB/MULT unit with saturation; the iterative
// restoring divider for op 11 is compiled in only when AU_DIV_EN is defined.
module au_param #(
    parameter int unsigned W    = 24,
    parameter int unsigned FRAC = 14
) (
    input logic      clk,
    input logic      rst,
    au_param_if.slave bus
);
    localparam int unsigned M  = W - 1;
    localparam int unsigned SW = 2 * M + 1;
    localparam logic [M-1:0] MAX_MAG = '1;
`ifdef AU_DIV_EN
    localparam int unsigned N  = W - 1 + FRAC;
    localparam int unsigned CW = $clog2(N);
`endif

    typedef enum logic [1:0] {IDLE, EXEC, DIV, FIN} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t state, state_nx;
    op_t    op_q;
    logic          x_sign, y_sign;
    logic [M-1:0]  x_mag, y_mag;
    logic [SW-1:0] stage_mag;
    logic          stage_sign;
    logic [W-1:0]  y_in;
    logic [SW-1:0] exec_mag;
    logic          exec_sign;
    logic          eff_ysign;
    logic [SW-1:0] raw_mag;
    logic          raw_sign;
    logic [M-1:0]  out_mag;
    logic          out_sign;
    logic          fin_ovf, fin_err;

`ifdef AU_DIV_EN
    logic [N-1:0]  quo;
    logic [M-1:0]  rem;
    logic [CW-1:0] cnt;
    logic [M:0]    rem_sh;
    logic [M-1:0]  rem_sub;
    logic          div_ge;

    // Remainder stays below |Y|, so the M-bit wraparound subtract is exact.
    always_comb begin
        rem_sh  = {rem, quo[N-1]};
        div_ge  = (rem_sh >= {1'b0, y_mag});
        rem_sub = rem_sh[M-1:0] - y_mag;
    end
`endif

    always_comb begin
        y_in = bus.S_in;
        if (bus.op_sel[1]) begin
            case (bus.mul_y_sel)
                2'b01:   y_in = bus.Iimm_in;
                2'b10:   y_in = W'(1) << FRAC;
                default: y_in = bus.S_in;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
`ifdef AU_DIV_EN
                    state_nx = (op_t'(bus.op_sel) == OP_DIV) ? DIV : EXEC;
`else
                    state_nx = EXEC;
`endif
                end
            end
            EXEC: state_nx = FIN;
            DIV: begin
`ifdef AU_DIV_EN
                if (y_mag == '0 || cnt == CW'(N - 1)) state_nx = FIN;
`else
                state_nx = IDLE;
`endif
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        eff_ysign = y_sign ^ (op_q == OP_SUB);
        exec_mag  = '0;
        exec_sign = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                if (x_sign == eff_ysign) begin
                    exec_mag  = SW'(x_mag) + SW'(y_mag);
                    exec_sign = x_sign;
                end else if (x_mag >= y_mag) begin
                    exec_mag  = SW'(x_mag - y_mag);
                    exec_sign = x_sign;
                end else begin
                    exec_mag  = SW'(y_mag - x_mag);
                    exec_sign = eff_ysign;
                end
            end
            OP_MUL: begin
                exec_mag  = (SW'(x_mag) * SW'(y_mag) + (SW'(1) << (FRAC - 1))) >> FRAC;
                exec_sign = x_sign ^ y_sign;
            end
            default: begin
                exec_mag  = '0;
                exec_sign = 1'b0;
            end
        endcase
    end

    always_comb begin
        raw_mag  = stage_mag;
        raw_sign = stage_sign;
        fin_ovf  = 1'b0;
        fin_err  = 1'b0;
`ifdef AU_DIV_EN
        if (op_q == OP_DIV) begin
            raw_mag  = SW'(quo);
            raw_sign = x_sign ^ y_sign;
        end
`endif
        if (raw_mag > SW'(MAX_MAG)) begin
            out_mag = MAX_MAG;
            fin_ovf = 1'b1;
        end else begin
            out_mag = raw_mag[M-1:0];
        end
        out_sign = raw_sign;
`ifdef AU_DIV_EN
        if (op_q == OP_DIV && y_mag == '0) begin
            out_mag  = MAX_MAG;
            out_sign = x_sign;
            fin_ovf  = 1'b1;
        end
`else
        if (op_q == OP_DIV) begin
            out_mag = '0;
            fin_ovf = 1'b0;
            fin_err = 1'b1;
        end
`endif
        if (out_mag == '0) out_sign = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_ADD;
            x_sign     <= 1'b0;
            x_mag      <= '0;
            y_sign     <= 1'b0;
            y_mag      <= '0;
            stage_mag  <= '0;
            stage_sign <= 1'b0;
            bus.result <= '0;
            bus.done   <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.err    <= 1'b0;
`ifdef AU_DIV_EN
            quo        <= '0;
            rem        <= '0;
            cnt        <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= op_t'(bus.op_sel);
                        x_sign <= bus.R_in[W-1];
                        x_mag  <= bus.R_in[M-1:0];
                        y_sign <= y_in[W-1];
                        y_mag  <= y_in[M-1:0];
`ifdef AU_DIV_EN
                        quo    <= {bus.R_in[M-1:0], {FRAC{1'b0}}};
                        rem    <= '0;
                        cnt    <= '0;
`endif
                    end
                end
                EXEC: begin
                    stage_mag  <= exec_mag;
                    stage_sign <= exec_sign;
                end
                DIV: begin
`ifdef AU_DIV_EN
                    if (y_mag != '0) begin
                        quo <= {quo[N-2:0], div_ge};
                        rem <= div_ge ? rem_sub : rem_sh[M-1:0];
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                FIN: begin
                    bus.result <= {out_sign, out_mag};
                    bus.ovf    <= fin_ovf;
                    bus.err    <= fin_err;
                    bus.done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_au_param.sv
// Directed scoreboard bench for au_param (defaults W=24, FRAC=14); DIV cases
// follow the AU_DIV_EN build.
module tb_au_param;
    localparam int unsigned W    = 24;
    localparam int unsigned FRAC = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    au_param_if #(.W(W)) bus ();
    au_param #(.W(W), .FRAC(FRAC)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [23:0] res;
        logic        ovf;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] enc(input int v);
        logic [23:0] r;
        int a;
        a = (v < 0) ? -v : v;
        r = 24'(a) << FRAC;
        if (v < 0 && a != 0) r[23] = 1'b1;
        return r;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [1:0] ysel,
                         input logic [23:0] r, input logic [23:0] s, input logic [23:0] imm);
        bus.start     = 1'b1;
        bus.op_sel    = op;
        bus.mul_y_sel = ysel;
        bus.R_in      = r;
        bus.S_in      = s;
        bus.Iimm_in   = imm;
    endtask

    task automatic scramble();
        bus.R_in      = 24'($urandom);
        bus.S_in      = 24'($urandom);
        bus.Iimm_in   = 24'($urandom);
        bus.op_sel    = 2'($urandom);
        bus.mul_y_sel = 2'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [1:0] ysel,
                          input logic [23:0] r, input logic [23:0] s, input logic [23:0] imm,
                          input logic [23:0] eres, input logic eovf, input logic eerr, input int elat);
        exp_t e;
        int lat;
        logic seen;
        e.res = eres; e.ovf = eovf; e.err = eerr; e.lat = elat;
        sb.push_back(e);
        @(negedge clk);
        drive(op, ysel, r, s, imm);
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble();
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            seen = bus.done;
        end
        e = sb.pop_front();
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " result"}, 32'(bus.result), 32'(e.res));
        check({tag, " ovf"}, 32'(bus.ovf), 32'(e.ovf));
        check({tag, " err"}, 32'(bus.err), 32'(e.err));
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " idle_after"}, 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int lat;
        logic seen;
        logic [23:0] held_exp;
        int held_lat;

        rst = 1'b1;
        bus.start = 1'b0;
        drive(2'b00, 2'b00, '0, '0, '0);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset result", 32'(bus.result), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset ovf", 32'(bus.ovf), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int a = -4; a <= 4; a++) begin
            for (int b = -4; b <= 4; b++) begin
                run_op($sformatf("add %0d+%0d", a, b), 2'b00, 2'b00, enc(a), enc(b), 24'h0, enc(a + b), 1'b0, 1'b0, 2);
                run_op($sformatf("sub %0d-%0d", a, b), 2'b01, 2'b00, enc(a), enc(b), 24'h0, enc(a - b), 1'b0, 1'b0, 2);
            end
        end
        run_op("sub 3-3 no neg zero", 2'b01, 2'b00, enc(3), enc(3), 24'h0, 24'h000000, 1'b0, 1'b0, 2);
        run_op("add ignores imm", 2'b00, 2'b01, enc(1), enc(1), enc(3), enc(2), 1'b0, 1'b0, 2);
        run_op("add at max", 2'b00, 2'b00, 24'h7FFFFF, 24'h000000, 24'h0, 24'h7FFFFF, 1'b0, 1'b0, 2);
        run_op("add max+lsb", 2'b00, 2'b00, 24'h7FFFFF, 24'h000001, 24'h0, 24'h7FFFFF, 1'b1, 1'b0, 2);

        run_op("mul 3x-2", 2'b10, 2'b00, 24'h00C000, 24'h808000, 24'h0, 24'h818000, 1'b0, 1'b0, 2);
        run_op("mul imm 1.5x0.5", 2'b10, 2'b01, 24'h006000, 24'h123456, 24'h002000, 24'h003000, 1'b0, 1'b0, 2);
        run_op("mul one", 2'b10, 2'b10, 24'h818000, 24'h004000, 24'h001000, 24'h818000, 1'b0, 1'b0, 2);
        run_op("mul ysel11 3x3", 2'b10, 2'b11, 24'h00C000, 24'h00C000, 24'h002000, 24'h024000, 1'b0, 1'b0, 2);
        run_op("mul round half up", 2'b10, 2'b01, 24'h000001, 24'h0, 24'h002000, 24'h000001, 1'b0, 1'b0, 2);
        run_op("mul round half neg", 2'b10, 2'b01, 24'h800001, 24'h0, 24'h002000, 24'h800001, 1'b0, 1'b0, 2);
        run_op("mul tiny neg to zero", 2'b10, 2'b00, 24'h000001, 24'h800001, 24'h0, 24'h000000, 1'b0, 1'b0, 2);
        run_op("mul sat", 2'b10, 2'b00, 24'h4B0000, 24'h4B0000, 24'h0, 24'h7FFFFF, 1'b1, 1'b0, 2);

        run_op("sat 300+300", 2'b00, 2'b00, 24'h4B0000, 24'h4B0000, 24'h0, 24'h7FFFFF, 1'b1, 1'b0, 2);
        run_op("after sat 1+1", 2'b00, 2'b00, enc(1), enc(1), 24'h0, 24'h008000, 1'b0, 1'b0, 2);

`ifdef AU_DIV_EN
        run_op("div 7/2", 2'b11, 2'b00, enc(7), enc(2), 24'h0, 24'h00E000, 1'b0, 1'b0, 38);
        run_op("div -5/0", 2'b11, 2'b00, enc(-5), 24'h000000, 24'h0, 24'hFFFFFF, 1'b1, 1'b0, 2);
        run_op("div by one", 2'b11, 2'b10, enc(-7), 24'h000000, 24'h0, enc(-7), 1'b0, 1'b0, 38);
        run_op("div sat 300/0.5", 2'b11, 2'b01, 24'h4B0000, enc(9), 24'h002000, 24'h7FFFFF, 1'b1, 1'b0, 38);
        run_op("div tiny neg trunc", 2'b11, 2'b00, 24'h800001, enc(2), 24'h0, 24'h000000, 1'b0, 1'b0, 38);
        held_exp = 24'h00E000;
        held_lat = 38;
`else
        run_op("op11 illegal", 2'b11, 2'b00, enc(7), enc(2), 24'h0, 24'h000000, 1'b0, 1'b1, 2);
        run_op("op11 after sat", 2'b00, 2'b00, 24'h4B0000, 24'h4B0000, 24'h0, 24'h7FFFFF, 1'b1, 1'b0, 2);
        run_op("op11 clears ovf", 2'b11, 2'b01, enc(-5), enc(0), enc(1), 24'h000000, 1'b0, 1'b1, 2);
        held_exp = 24'h000000;
        held_lat = 2;
`endif

        // start held high for the whole op: only one op may run
        @(negedge clk);
        drive(2'b11, 2'b00, enc(7), enc(2), 24'h0);
        @(posedge clk); #1;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            seen = bus.done;
        end
        bus.start = 1'b0;
        check("held done_seen", 32'(seen), 32'd1);
        check("held latency", 32'(lat), 32'(held_lat));
        check("held result", 32'(bus.result), 32'(held_exp));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("held no second done %0d", i), 32'(bus.done), 32'd0);
            check($sformatf("held idle %0d", i), 32'(bus.busy), 32'd0);
        end

        // reset in the middle of an op, after a saturating op left ovf set
        run_op("pre-reset sat", 2'b00, 2'b00, 24'h4B0000, 24'h4B0000, 24'h0, 24'h7FFFFF, 1'b1, 1'b0, 2);
        @(negedge clk);
`ifdef AU_DIV_EN
        drive(2'b11, 2'b00, enc(7), enc(2), 24'h0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("mid-div no done %0d", i), 32'(bus.done), 32'd0);
        end
`else
        drive(2'b10, 2'b00, 24'h00C000, 24'h808000, 24'h0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("mid-op no done", 32'(bus.done), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort result", 32'(bus.result), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort ovf", 32'(bus.ovf), 32'd0);
        check("abort err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        run_op("after abort 1+1", 2'b00, 2'b00, enc(1), enc(1), 24'h0, 24'h008000, 1'b0, 1'b0, 2);
        run_op("after abort mul", 2'b10, 2'b00, 24'h00C000, 24'h808000, 24'h0, 24'h818000, 1'b0, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
